instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning instruction-memory byte-address width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, one-cycle pulse that begins a load session.
REQ-005 SHALL have port base_addr, input, ADDR_W, first write byte address, sampled with start.
REQ-006 SHALL have port in_valid, input, 1, producer offers an operation.
REQ-007 SHALL have port in_ready, output, 1, encoder accepts the operation this cycle.
REQ-008 SHALL have port in_op, input, 4, operation code: ADD, ADDI, LBU, SB, LUI, BNE, BGEU, JALR, JAL.
REQ-009 SHALL have ports in_rd, in_rs1 and in_rs2, input, 5 each, register indices.
REQ-010 SHALL have port in_imm, input, 32, signed immediate or byte offset; for LUI, the full 32-bit value.
REQ-011 SHALL have port in_last, input, 1, marks the final operation of the session.
REQ-012 SHALL have port imem_we, output, 1, instruction-memory write strobe.
REQ-013 SHALL have port imem_addr, output, ADDR_W, byte address of the written word.
REQ-014 SHALL have port imem_wdata, output, 32, encoded RV32I instruction word.
REQ-015 SHALL have ports done (1-cycle pulse), full (level) and err (sticky), outputs, 1 each.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD and FULL.
REQ-017 IDLE: start SHALL latch base_addr into the address counter and enter LOAD; in_ready SHALL be 0.
REQ-018 LOAD: in_ready SHALL be 1; a transfer SHALL occur only when in_valid and in_ready are both 1.
REQ-019 Each transfer SHALL produce imem_we=1, with the encoded word and the current address, on the next cycle (latency 1).
REQ-020 The address SHALL advance by 4 after each write.
REQ-021 Encoding SHALL follow the RV32I I/S/B/U/J field layouts:
- ADD: funct3 000, funct7 0.
- ADDI: funct3 000.
- LBU: funct3 100.
- SB: funct3 000.
- BNE: funct3 001.
- BGEU: funct3 111.
- JALR: funct3 000.
REQ-022 LUI SHALL use in_imm[31:12]; B and J immediates SHALL use bit 0 discarded.
REQ-023 Unused fields (for example rs2 for I-type) SHALL be encoded as 0.
REQ-024 An undefined in_op SHALL write NOP 0x00000013 and set err.
REQ-025 Transfer with in_last=1: done SHALL pulse on the write cycle, and the FSM SHALL return to IDLE.
REQ-026 Transfer whose write address equals 2^ADDR_W-4 without in_last: the FSM SHALL enter FULL after the write; full SHALL be 1 and in_ready 0; the address SHALL NOT wrap.
REQ-027 FULL SHALL exit to IDLE only on start, which behaves as in IDLE and clears full.
REQ-028 start in LOAD SHALL be ignored.
REQ-029 err SHALL clear only on start or rst.

Reset
REQ-030 rst SHALL take priority over all inputs.
REQ-031 On rst the FSM SHALL be IDLE, and imem_we, done, full, err and in_ready SHALL be 0.
REQ-032 On rst imem_addr and imem_wdata SHALL be 0.
REQ-033 rst during LOAD SHALL discard the pending write, so imem_we is 0 on the following cycle.

Configuration
REQ-034 With INSTR_ENC_RANGE_CHECK_EN defined, an out-of-range immediate SHALL write NOP and set err. Limits:
- I/S: signed 12-bit.
- B: signed 13-bit and even.
- J: signed 21-bit and even.
- LUI: in_imm[11:0]=0.
REQ-035 Without INSTR_ENC_RANGE_CHECK_EN, immediates SHALL be silently truncated and err SHALL be set only by REQ-024.

Structure
REQ-036 A shared package instr_enc_pkg SHALL hold the in_op enum, the opcode localparams, the funct3 values and NOP.
REQ-037 A combinational sub-module imm_packer SHALL map in_imm and format to immediate bit positions, plus an in-range flag.

Verification
REQ-038 start base_addr=0x100; ADDI rd=1, rs1=0, imm=5 -> imem_we next cycle, addr 0x100, wdata 0x00500093.
REQ-039 Back-to-back transfers:
- ADD rd=3, rs1=1, rs2=2 -> 0x002081B3 at 0x100.
- LUI rd=5, imm=0x12345000 -> 0x123452B7 at 0x104.
REQ-040 BNE rs1=1, rs2=2, imm=-4 -> 0xFE209EE3; JAL rd=1, imm=8 with in_last -> 0x008000EF plus a done pulse; IDLE follows.
REQ-041 base_addr=2^ADDR_W-8, three ops offered -> two writes, then full=1 and in_ready=0; the third op is not accepted.
REQ-042 Error cases:
- ADDI imm=4096 with the macro defined -> 0x00000013, err=1.
- The same op without the macro -> 0x00000093 (imm truncated to 0), err=0.
- in_op=0xF -> NOP, err=1.
REQ-043 rst asserted on the cycle after a transfer -> imem_we=0 on the next cycle, FSM in IDLE; a following start resumes normally.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// Holds the operation codes, the instruction formats, the FSM states,
// the RV32I major opcodes, the funct3 values and the canonical NOP.
package instr_enc_pkg;

  // Operation codes accepted on in_op; codes 9..15 are undefined.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDI = 4'd1,
    OP_LBU  = 4'd2,
    OP_SB   = 4'd3,
    OP_LUI  = 4'd4,
    OP_BNE  = 4'd5,
    OP_BGEU = 4'd6,
    OP_JALR = 4'd7,
    OP_JAL  = 4'd8
  } op_e;

  // RV32I instruction formats; selects the immediate bit layout.
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // Load-session controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  // Major opcodes, instruction bits [6:0].
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // funct3 values, instruction bits [14:12].
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_JALR = 3'b000;

  // addi x0, x0, 0 -- written in place of anything that cannot be encoded.
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_encoder_imm_packer.sv
// imm_packer: scatters a 32-bit immediate into the instruction-word bit
// positions of the selected RV32I format (all other bits zero) and reports
// whether the immediate is representable.
// Optional feature: INSTR_ENC_RANGE_CHECK_EN enables the range check;
// without it in_range is always 1 and immediates are silently truncated.
module imm_packer
  import instr_enc_pkg::*;
(
  input  logic [31:0] imm,
  input  logic [2:0]  fmt,
  output logic [31:0] imm_bits,
  output logic        in_range
);

  // Place immediate bits according to the format; B/J drop imm[0].
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    imm_bits = '0;
    case (fmt)
      FMT_I:   imm_bits = {imm[11:0], 20'b0};
      FMT_S:   imm_bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
      FMT_B:   imm_bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
      FMT_U:   imm_bits = {imm[31:12], 12'b0};
      FMT_J:   imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
      default: imm_bits = '0;
    endcase
  end

  // Representability: sign-extension bits must agree, branch/jump offsets even.
  always_comb begin
    in_range = 1'b1;
`ifdef INSTR_ENC_RANGE_CHECK_EN
    case (fmt)
      FMT_I, FMT_S: in_range = (&imm[31:11]) | ~(|imm[31:11]);
      FMT_B:        in_range = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      FMT_J:        in_range = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
      FMT_U:        in_range = ~(|imm[11:0]);
      default:      in_range = 1'b1;
    endcase
`else
    in_range = 1'b1;
`endif
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts operations over a valid/ready handshake, encodes
// each into an RV32I word and writes it to instruction memory one cycle
// later at consecutive word addresses starting from base_addr.
// Optional feature: INSTR_ENC_RANGE_CHECK_EN (handled in imm_packer) turns
// out-of-range immediates into a NOP write with err set.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              full,
  output logic              err
);

  // Last word-aligned address; a write here without in_last fills memory.
  localparam logic [ADDR_W-1:0] ADDR_TOP  = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_cnt;
  logic              xfer, start_take, at_top;

  fmt_e              fmt;
  logic [6:0]        opc;
  logic [2:0]        f3;
  logic              use_rd, use_rs1, use_rs2, op_bad;
  logic [31:0]       imm_bits, word;
  logic              in_range, bad;

  assign in_ready   = (state_q == ST_LOAD);
  assign full       = (state_q == ST_FULL);
  assign xfer       = in_valid & in_ready;
  assign start_take = start & (state_q != ST_LOAD);
  assign at_top     = (addr_cnt == ADDR_TOP);

  // Decode the operation into format, opcode, funct3 and used register fields.
  always_comb begin
    fmt     = FMT_I;
    opc     = OPC_OP_IMM;
    f3      = 3'b000;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    op_bad  = 1'b0;
    case (in_op)
      OP_ADD:  begin fmt = FMT_R; opc = OPC_OP;     f3 = F3_ADD;  use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_ADDI: begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_ADDI; use_rd = 1'b1; use_rs1 = 1'b1; end
      OP_LBU:  begin fmt = FMT_I; opc = OPC_LOAD;   f3 = F3_LBU;  use_rd = 1'b1; use_rs1 = 1'b1; end
      OP_SB:   begin fmt = FMT_S; opc = OPC_STORE;  f3 = F3_SB;   use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_LUI:  begin fmt = FMT_U; opc = OPC_LUI;    use_rd = 1'b1; end
      OP_BNE:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BNE;  use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_BGEU: begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGEU; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_JALR: begin fmt = FMT_I; opc = OPC_JALR;   f3 = F3_JALR; use_rd = 1'b1; use_rs1 = 1'b1; end
      OP_JAL:  begin fmt = FMT_J; opc = OPC_JAL;    use_rd = 1'b1; end
      default: op_bad = 1'b1;
    endcase
  end

  imm_packer u_imm_packer (
    .imm      (in_imm),
    .fmt      (fmt),
    .imm_bits (imm_bits),
    .in_range (in_range)
  );

  // Assemble the word; unused register fields stay zero, bad ops become NOP.
  always_comb begin
    bad  = op_bad | ~in_range;
    word = imm_bits | {7'b0,
                       use_rs2 ? in_rs2 : 5'd0,
                       use_rs1 ? in_rs1 : 5'd0,
                       f3,
                       use_rd  ? in_rd  : 5'd0,
                       opc};
    if (bad) word = NOP;
  end

  // Session control: start opens a session, in_last or a full memory ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (xfer) begin
          if (in_last)     state_d = ST_IDLE;
          else if (at_top) state_d = ST_FULL;
        end
      end
      ST_FULL: if (start) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Write port, address counter and status flags; rst discards a pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      addr_cnt   <= '0;
    end else begin
      imem_we <= xfer;
      done    <= xfer & in_last;
      if (start_take) begin
        addr_cnt <= base_addr;
        err      <= 1'b0;
      end else if (xfer) begin
        imem_addr  <= addr_cnt;
        imem_wdata <= word;
        if (bad)     err      <= 1'b1;
        if (!at_top) addr_cnt <= addr_cnt + ADDR_STEP;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table of single-op sessions with
// hand-computed RV32I words, plus directed sequences for back-to-back
// transfers, start ignored in LOAD, memory-full, and reset mid-session.
// Honours INSTR_ENC_RANGE_CHECK_EN for the range-dependent expectations.
module tb_instr_encoder;
  import instr_enc_pkg::*;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst, start, in_valid, in_ready, in_last;
  logic [ADDR_W-1:0] base_addr, imem_addr;
  logic [3:0]        in_op;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [31:0]       in_imm, imem_wdata;
  logic              imem_we, done, full, err;

  int checks = 0;
  int failures = 0;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .done       (done),
    .full       (full),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp_word;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic last);
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    in_last  = last;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] base);
    start     = 1'b1;
    base_addr = base;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    // op, rd, rs1, rs2, imm, expected word, expected err
    vecs[0]  = '{4'(OP_ADDI), 5'd1, 5'd0, 5'd9, 32'd5,          32'h0050_0093, 1'b0};
    vecs[1]  = '{4'(OP_ADD),  5'd3, 5'd1, 5'd2, 32'd0,          32'h0020_81B3, 1'b0};
    vecs[2]  = '{4'(OP_LUI),  5'd5, 5'd7, 5'd7, 32'h1234_5000,  32'h1234_52B7, 1'b0};
    vecs[3]  = '{4'(OP_BNE),  5'd9, 5'd1, 5'd2, -32'sd4,        32'hFE20_9EE3, 1'b0};
    vecs[4]  = '{4'(OP_JAL),  5'd1, 5'd3, 5'd3, 32'd8,          32'h0080_00EF, 1'b0};
    vecs[5]  = '{4'(OP_LBU),  5'd2, 5'd3, 5'd4, 32'hFFFF_FFFF,  32'hFFF1_C103, 1'b0};
    vecs[6]  = '{4'(OP_SB),   5'd7, 5'd2, 5'd5, 32'd20,         32'h0051_0A23, 1'b0};
    vecs[7]  = '{4'(OP_BGEU), 5'd0, 5'd4, 5'd6, 32'd16,         32'h0062_7863, 1'b0};
    vecs[8]  = '{4'(OP_JALR), 5'd0, 5'd1, 5'd0, 32'd0,          32'h0000_8067, 1'b0};
    vecs[9]  = '{4'hF,        5'd1, 5'd1, 5'd1, 32'd0,          32'h0000_0013, 1'b1};
    vecs[10] = '{4'(OP_JAL),  5'd0, 5'd0, 5'd0, -32'sd8,        32'hFF9F_F06F, 1'b0};
    vecs[11] = '{4'(OP_ADDI), 5'd1, 5'd0, 5'd0, -32'sd2048,     32'h8000_0093, 1'b0};
`ifdef INSTR_ENC_RANGE_CHECK_EN
    vecs[12] = '{4'(OP_ADDI), 5'd1, 5'd0, 5'd0, 32'd4096,       32'h0000_0013, 1'b1};
    vecs[13] = '{4'(OP_LUI),  5'd1, 5'd0, 5'd0, 32'h0000_1001,  32'h0000_0013, 1'b1};
`else
    vecs[12] = '{4'(OP_ADDI), 5'd1, 5'd0, 5'd0, 32'd4096,       32'h0000_0093, 1'b0};
    vecs[13] = '{4'(OP_LUI),  5'd1, 5'd0, 5'd0, 32'h0000_1001,  32'h0000_10B7, 1'b0};
`endif

    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    tick();
    tick();
    check("rst_we",    32'(imem_we),    32'd0);
    check("rst_addr",  32'(imem_addr),  32'd0);
    check("rst_wdata", imem_wdata,      32'd0);
    check("rst_flags", {28'd0, done, full, err, in_ready}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_ready", 32'(in_ready), 32'd0);

    // One-op sessions from the table; the first is also the basic latency case.
    for (int i = 0; i < NVEC; i++) begin
      do_start(ADDR_W'(12'h100));
      check($sformatf("v%0d_ready", i),   32'(in_ready), 32'd1);
      check($sformatf("v%0d_errclr", i),  32'(err),      32'd0);
      set_op(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 1'b1);
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d_we", i),    32'(imem_we),   32'd1);
      check($sformatf("v%0d_addr", i),  32'(imem_addr), 32'h100);
      check($sformatf("v%0d_word", i),  imem_wdata,     vecs[i].exp_word);
      check($sformatf("v%0d_err", i),   32'(err),       32'(vecs[i].exp_err));
      check($sformatf("v%0d_done", i),  32'(done),      32'd1);
      check($sformatf("v%0d_idle", i),  32'(in_ready),  32'd0);
      tick();
      check($sformatf("v%0d_we_off", i),   32'(imem_we), 32'd0);
      check($sformatf("v%0d_done_off", i), 32'(done),    32'd0);
    end

    // Back-to-back session; start with the second op must be ignored.
    do_start(ADDR_W'(12'h100));
    set_op(4'(OP_ADD), 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    tick();
    check("b2b0_addr", 32'(imem_addr), 32'h100);
    check("b2b0_word", imem_wdata,     32'h0020_81B3);
    check("b2b0_done", 32'(done),      32'd0);
    set_op(4'(OP_LUI), 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
    start = 1'b1; base_addr = ADDR_W'(12'h200);
    tick();
    start = 1'b0;
    check("b2b1_we",   32'(imem_we),   32'd1);
    check("b2b1_addr", 32'(imem_addr), 32'h104);
    check("b2b1_word", imem_wdata,     32'h1234_52B7);
    set_op(4'(OP_BNE), 5'd0, 5'd1, 5'd2, -32'sd4, 1'b0);
    tick();
    check("b2b2_addr", 32'(imem_addr), 32'h108);
    check("b2b2_word", imem_wdata,     32'hFE20_9EE3);
    set_op(4'(OP_JAL), 5'd1, 5'd0, 5'd0, 32'd8, 1'b1);
    tick();
    in_valid = 1'b0;
    check("b2b3_addr", 32'(imem_addr), 32'h10C);
    check("b2b3_word", imem_wdata,     32'h0080_00EF);
    check("b2b3_done", 32'(done),      32'd1);
    check("b2b3_idle", 32'(in_ready),  32'd0);

    // Memory-full: two writes at the top, third op refused, no wrap.
    do_start(ADDR_W'(12'h3F8));
    set_op(4'(OP_ADDI), 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
    tick();
    check("full0_addr", 32'(imem_addr), 32'h3F8);
    check("full0_flag", 32'(full),      32'd0);
    set_op(4'(OP_ADDI), 5'd2, 5'd0, 5'd0, 32'd2, 1'b0);
    tick();
    check("full1_we",    32'(imem_we),   32'd1);
    check("full1_addr",  32'(imem_addr), 32'h3FC);
    check("full1_flag",  32'(full),      32'd1);
    check("full1_ready", 32'(in_ready),  32'd0);
    set_op(4'(OP_ADDI), 5'd3, 5'd0, 5'd0, 32'd3, 1'b0);
    tick();
    tick();
    check("full2_we",   32'(imem_we),   32'd0);
    check("full2_flag", 32'(full),      32'd1);
    check("full2_addr", 32'(imem_addr), 32'h3FC);
    in_valid = 1'b0;
    do_start(ADDR_W'(12'h000));
    check("full_exit_flag",  32'(full),     32'd0);
    check("full_exit_ready", 32'(in_ready), 32'd1);
    set_op(4'(OP_ADDI), 5'd4, 5'd0, 5'd0, 32'd4, 1'b1);
    tick();
    in_valid = 1'b0;
    check("full_exit_addr", 32'(imem_addr), 32'h000);
    check("full_exit_word", imem_wdata,     32'h0040_0213);

    // Reset on the cycle after a transfer drops the write and returns to IDLE.
    do_start(ADDR_W'(12'h040));
    set_op(4'(OP_ADDI), 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    tick();
    in_valid = 1'b0;
    check("rstl_we_pre", 32'(imem_we), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstl_we",    32'(imem_we),  32'd0);
    check("rstl_ready", 32'(in_ready), 32'd0);
    check("rstl_wdata", imem_wdata,    32'd0);
    do_start(ADDR_W'(12'h080));
    set_op(4'(OP_JALR), 5'd0, 5'd1, 5'd0, 32'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    check("rstl_resume_we",   32'(imem_we),   32'd1);
    check("rstl_resume_addr", 32'(imem_addr), 32'h080);
    check("rstl_resume_word", imem_wdata,     32'h0000_8067);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
